banked_shared_memory: RTL

- Parametrised successor of the 16-core shared memory; N_CORES cores share one scratchpad split into N_BANKS single-port banks.
- Each bank has its own round-robin arbiter, so requests to different banks complete in parallel and requests to the same bank are serialised fairly.
- Sits between the core array and the on-chip SRAM.
- Core ports are flattened buses indexed by core number.

---
 rtl/sm_pkg.sv | 35 +++
 rtl/sm_bank.sv | 92 +++++++++
 rtl/banked_shared_memory.sv | 73 +++++++
 3 files changed

// File: rtl/sm_pkg.sv
// Shared constants, bank-width helper and request-kind encoding
// for the banked shared memory.
package sm_pkg;

    localparam int N_CORES_DEF = 16;
    localparam int N_BANKS_DEF = 16;
    localparam int ADDR_W_DEF  = 12;
    localparam int DATA_W_DEF  = 8;

    typedef enum logic [1:0] {
        REQ_IDLE  = 2'd0,
        REQ_READ  = 2'd1,
        REQ_WRITE = 2'd2
    } req_kind_t;

    function automatic int bank_w(input int n_banks);
        return $clog2(n_banks);
    endfunction

    // A request carrying both read and write is a write.
    function automatic req_kind_t req_kind(
        input logic val,
        input logic rd,
        input logic wr
    );
        if (!val)
            return REQ_IDLE;
        if (wr)
            return REQ_WRITE;
        if (rd)
            return REQ_READ;
        return REQ_IDLE;
    endfunction

endpackage

// File: rtl/sm_bank.sv
// One single-port bank with its own round-robin arbiter.
// SM_BCAST_READ_EN lets identical-row reads share one grant.
module sm_bank
    import sm_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BANK_W  = 4,
    parameter int BANK_ID = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_CORES-1:0]        core_val,
    input  logic [N_CORES-1:0]        read,
    input  logic [N_CORES-1:0]        write,
    input  logic [N_CORES-1:0]        finish,
    input  logic [N_CORES*ADDR_W-1:0] addr_in,
    input  logic [N_CORES*DATA_W-1:0] data_in,
    output logic [N_CORES-1:0]        grant,
    output logic [DATA_W-1:0]         rd_word
);

    localparam int ROW_W = ADDR_W - BANK_W;
    localparam int DEPTH = 1 << ROW_W;
    localparam int PTR_W = $clog2(N_CORES);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  gsel;
    logic              found;
    logic              we;
    logic [N_CORES-1:0] match;
    logic [ROW_W-1:0]  row [N_CORES];
    req_kind_t         kind [N_CORES];
    int                idx;

    // Nothing is eligible while reset is held, so no access slips in.
    always_comb begin
        for (int i = 0; i < N_CORES; i++) begin
            kind[i]  = req_kind(core_val[i], read[i], write[i]);
            row[i]   = addr_in[i*ADDR_W+BANK_W +: ROW_W];
            match[i] = reset && (kind[i] != REQ_IDLE) && !finish[i]
                && (addr_in[i*ADDR_W +: BANK_W] == BANK_W'(BANK_ID));
        end
    end

    always_comb begin
        found = 1'b0;
        gsel  = '0;
        idx   = 0;
        for (int k = 0; k < N_CORES; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_CORES)
                idx = idx - N_CORES;
            if (!found && match[idx]) begin
                found = 1'b1;
                gsel  = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        grant = '0;
        if (found)
            grant[gsel] = 1'b1;
`ifdef SM_BCAST_READ_EN
        if (found && kind[gsel] == REQ_READ) begin
            for (int i = 0; i < N_CORES; i++) begin
                if (match[i] && kind[i] == REQ_READ && row[i] == row[gsel])
                    grant[i] = 1'b1;
            end
        end
`endif
    end

    assign we      = found && (kind[gsel] == REQ_WRITE);
    assign rd_word = mem[row[gsel]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            rr_ptr <= '0;
        else if (found)
            rr_ptr <= (gsel == PTR_W'(N_CORES - 1)) ? '0 : gsel + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (we)
            mem[row[gsel]] <= data_in[int'(gsel)*DATA_W +: DATA_W];
    end

endmodule

// File: rtl/banked_shared_memory.sv
// N_CORES cores sharing N_BANKS independently arbitrated banks.
// Define SM_BCAST_READ_EN to broadcast same-row reads within a bank.
module banked_shared_memory
    import sm_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEF,
    parameter int N_BANKS = N_BANKS_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N_CORES-1:0]        core_val,
    input  logic [N_CORES-1:0]        read,
    input  logic [N_CORES-1:0]        write,
    input  logic [N_CORES*ADDR_W-1:0] addr_in,
    input  logic [N_CORES*DATA_W-1:0] data_in,
    output logic [N_CORES*DATA_W-1:0] data_out,
    output logic [N_CORES-1:0]        finish
);

    localparam int BANK_W = bank_w(N_BANKS);

    logic [N_CORES-1:0]        grant   [N_BANKS];
    logic [DATA_W-1:0]         rd_word [N_BANKS];
    logic [N_CORES-1:0]        done;
    logic [N_CORES*DATA_W-1:0] rd_next;

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        sm_bank #(
            .N_CORES (N_CORES),
            .ADDR_W  (ADDR_W),
            .DATA_W  (DATA_W),
            .BANK_W  (BANK_W),
            .BANK_ID (b)
        ) u_bank (
            .clock    (clock),
            .reset    (reset),
            .core_val (core_val),
            .read     (read),
            .write    (write),
            .finish   (finish),
            .addr_in  (addr_in),
            .data_in  (data_in),
            .grant    (grant[b]),
            .rd_word  (rd_word[b])
        );
    end

    // A core addresses one bank, so its read data comes from that bank.
    always_comb begin
        done    = '0;
        rd_next = data_out;
        for (int b = 0; b < N_BANKS; b++)
            done = done | grant[b];
        for (int i = 0; i < N_CORES; i++) begin
            if (done[i] && !write[i])
                rd_next[i*DATA_W +: DATA_W] =
                    rd_word[addr_in[i*ADDR_W +: BANK_W]];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            finish   <= '0;
            data_out <= '0;
        end else begin
            finish   <= done;
            data_out <= rd_next;
        end
    end

endmodule
